// File: rtl/cl_code_lit_enc.sv
// cl_code_lit_enc
//   Canonical Huffman code assigner for the literal/length code-length tree.
//   When a build starts, the packed per-symbol code lengths are scanned once
//   for each length 1..MAXLEN in canonical order. Each symbol whose length
//   matches gets the next code value. The finished table then answers
//   registered symbol -> {code, length} lookups for the bit packer.
//
// Ports
//   clk          clock
//   rst          asynchronous, active-high reset
//   enb          start a table build (level, sampled in IDLE)
//   litTree      packed code lengths, symbol i at [4i+3:4i], 0 = unused
//   litSymb      lookup symbol index
//   fin_lit      table built and valid
//   err_oversub  code space oversubscribed (sticky until next build/reset)
//   litCode      code for litSymb, right-aligned
//   litLen       code length for litSymb, 0 = unused or out of range
//
// Optional feature
//   CL_CODE_LIT_REV_EN : when defined, litCode is bit-reversed within litLen
//   bits (LSB-first). The stored table and the build timing do not change.
module cl_code_lit_enc #(
  parameter int NSYM   = 29,
  parameter int MAXLEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enb,
  input  logic [4*NSYM-1:0]   litTree,
  input  logic [4:0]          litSymb,
  output logic                fin_lit,
  output logic                err_oversub,
  output logic [MAXLEN-1:0]   litCode,
  output logic [3:0]          litLen
);

  localparam int         CW        = MAXLEN + 1;
  localparam logic [4:0] LAST_POS  = 5'(NSYM - 1);
  localparam logic [4:0] SYM_LIM   = 5'(NSYM);

  // State values double as the length being scanned (LENk == k).
  typedef enum logic [3:0] {
    IDLE = 4'd0,
    LEN1 = 4'd1,
    LEN2 = 4'd2,
    LEN3 = 4'd3,
    LEN4 = 4'd4,
    LEN5 = 4'd5,
    LEN6 = 4'd6,
    LEN7 = 4'd7,
    LEN8 = 4'd8,
    FIN  = 4'd9
  } state_e;

  state_e              state_q, state_d;
  logic [4:0]          pos_q;
  logic [CW-1:0]       code_q, code_d;
  logic                fin_q;
  logic                err_q;
  logic [MAXLEN-1:0]   codeTbl_q [NSYM];
  logic [3:0]          lenTbl_q  [NSYM];
  logic [MAXLEN-1:0]   lookCode_q, lookCode_d;
  logic [3:0]          lookLen_q, lookLen_d;

  logic [3:0]          symLen [NSYM];
  logic [3:0]          curLen;
  logic [3:0]          curK;
  logic                scanning;
  logic                lastPos;
  logic                match;
  logic                overflow;
  logic                startBuild;
  logic [CW-1:0]       codeInc;

  always_comb begin
    for (int i = 0; i < NSYM; i++) begin
      symLen[i] = litTree[4*i +: 4];
    end
  end

  assign curK       = state_q;
  assign curLen     = symLen[pos_q];
  assign scanning   = (state_q != IDLE) && (state_q != FIN);
  assign lastPos    = (pos_q == LAST_POS);
  assign match      = scanning && (curLen == curK);
  // The code counter is one bit wider than MAXLEN so that running past
  // 2^k (including 2^8 at length 8) stays visible.
  assign overflow   = (code_q >= ({{(CW-1){1'b0}}, 1'b1} << curK));
  assign startBuild = (state_q == IDLE) && enb;

  // Canonical code step: a match consumes one code value, and moving on to
  // the next length doubles the code.
  always_comb begin
    codeInc = match ? (code_q + 1'b1) : code_q;
    code_d  = lastPos ? (codeInc << 1) : codeInc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // enb is only looked at in IDLE and FIN; once started, a build runs to
  // completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enb) state_d = LEN1;
      LEN1, LEN2, LEN3, LEN4, LEN5, LEN6, LEN7:
            if (lastPos) state_d = state_e'(state_q + 4'd1);
      LEN8: if (lastPos) state_d = FIN;
      FIN:  if (!enb) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scan datapath and table. fin_q is held after FIN so that lookups stay
  // valid in IDLE, and it is cleared only when a new build starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q  <= '0;
      code_q <= '0;
      fin_q  <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < NSYM; i++) begin
        codeTbl_q[i] <= '0;
        lenTbl_q[i]  <= '0;
      end
    end else if (startBuild) begin
      pos_q  <= '0;
      code_q <= '0;
      fin_q  <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < NSYM; i++) begin
        codeTbl_q[i] <= '0;
        lenTbl_q[i]  <= '0;
      end
    end else begin
      if (scanning) begin
        if (match) begin
          codeTbl_q[pos_q] <= code_q[MAXLEN-1:0];
          lenTbl_q[pos_q]  <= curK;
          if (overflow) err_q <= 1'b1;
        end
        pos_q  <= lastPos ? 5'd0 : (pos_q + 5'd1);
        code_q <= code_d;
      end
      if (state_q == FIN) fin_q <= 1'b1;
    end
  end

  // Lookup path: reads return zero until the table is valid, and also for
  // indices beyond the last symbol.
  always_comb begin
    logic [MAXLEN-1:0] selCode;
    logic [3:0]        selLen;
`ifdef CL_CODE_LIT_REV_EN
    logic [MAXLEN-1:0] rev;
`endif
    selCode = '0;
    selLen  = '0;
    if (fin_q && (litSymb < SYM_LIM)) begin
      selCode = codeTbl_q[litSymb];
      selLen  = lenTbl_q[litSymb];
    end
`ifdef CL_CODE_LIT_REV_EN
    // Reverse all MAXLEN bits, then shift the unused top part away so that
    // only the litLen-bit reversed code remains, right-aligned.
    rev        = {<<{selCode}};
    lookCode_d = rev >> (4'(MAXLEN) - selLen);
`else
    lookCode_d = selCode;
`endif
    lookLen_d  = selLen;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookCode_q <= '0;
      lookLen_q  <= '0;
    end else begin
      lookCode_q <= lookCode_d;
      lookLen_q  <= lookLen_d;
    end
  end

  assign fin_lit     = fin_q;
  assign err_oversub = err_q;
  assign litCode     = lookCode_q;
  assign litLen      = lookLen_q;

endmodule

// File: tb/tb_cl_code_lit_enc.sv
module tb_cl_code_lit_enc;

  logic         clk;
  logic         rst;
  logic         enb;
  logic [115:0] litTree;
  logic [4:0]   litSymb;
  logic         fin_lit;
  logic         err_oversub;
  logic [7:0]   litCode;
  logic [3:0]   litLen;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         scen;
    logic [4:0] sym;
    logic [7:0] code;
    logic [3:0] len;
  } vec_t;

  typedef struct {
    logic [7:0] code;
    logic [3:0] len;
  } exp_t;

  vec_t vecs[$];
  exp_t sbQ[$];

  cl_code_lit_enc dut (
    .clk         (clk),
    .rst         (rst),
    .enb         (enb),
    .litTree     (litTree),
    .litSymb     (litSymb),
    .fin_lit     (fin_lit),
    .err_oversub (err_oversub),
    .litCode     (litCode),
    .litLen      (litLen)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output form of a canonical (MSB-first) code.
  function automatic logic [7:0] expCode(input logic [7:0] c, input logic [3:0] len);
    logic [7:0] r;
    r = c;
`ifdef CL_CODE_LIT_REV_EN
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(len)) r[i] = c[int'(len) - 1 - i];
    end
`endif
    return r;
  endfunction

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive a lookup and queue the expected result in the scoreboard.
  task automatic applyStimulus(input logic [4:0] sym, input logic [7:0] code, input logic [3:0] len);
    exp_t e;
    @(negedge clk);
    litSymb = sym;
    e.code = expCode(code, len);
    e.len  = len;
    sbQ.push_back(e);
  endtask

  // One cycle after the lookup is applied, pop the queue and compare it with
  // the registered output.
  task automatic checkOutput(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    if (sbQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: scoreboard empty", name);
      return;
    end
    e = sbQ.pop_front();
    if (litCode !== e.code || litLen !== e.len) begin
      errors++;
      $display("[TB] FAIL %s: got code=%0d len=%0d expected code=%0d len=%0d",
               name, litCode, litLen, e.code, e.len);
    end
  endtask

  task automatic runVectors(input int scen);
    foreach (vecs[i]) begin
      if (vecs[i].scen == scen) begin
        applyStimulus(vecs[i].sym, vecs[i].code, vecs[i].len);
        checkOutput($sformatf("s%0d_sym%0d", scen, vecs[i].sym));
      end
    end
  endtask

  // Start a build and count the edges after the sampling edge until fin_lit
  // is seen. enb is dropped after 'hold' edges, which tests that enb has no
  // effect during the scan.
  task automatic buildTree(input string name, input logic [115:0] tree, input int hold);
    int cnt;
    @(negedge clk);
    litTree = tree;
    enb     = 1'b1;
    @(posedge clk);
    #1;
    if (hold == 0) enb = 1'b0;
    cnt = 0;
    while (cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == hold) enb = 1'b0;
      if (fin_lit) break;
    end
    enb = 1'b0;
    checkVal({name, "_fin_edges"}, cnt, 233);
  endtask

  task automatic checkAllZero(input string name);
    checkVal({name, "_fin"},  fin_lit,     0);
    checkVal({name, "_err"},  err_oversub, 0);
    checkVal({name, "_code"}, litCode,     0);
    checkVal({name, "_len"},  litLen,      0);
  endtask

  initial begin
    logic [115:0] tree1, tree2, tree3, tree5;

    // scen, sym, canonical code (MSB-first), len
    vecs.push_back('{1, 5'd0,  8'd0,  4'd5});
    vecs.push_back('{1, 5'd13, 8'd13, 4'd5});
    vecs.push_back('{1, 5'd28, 8'd28, 4'd5});
    vecs.push_back('{1, 5'd31, 8'd0,  4'd0});
    vecs.push_back('{2, 5'd0,  8'd0,  4'd1});
    vecs.push_back('{2, 5'd1,  8'd2,  4'd2});
    vecs.push_back('{2, 5'd2,  8'd6,  4'd3});
    vecs.push_back('{2, 5'd3,  8'd7,  4'd3});
    vecs.push_back('{2, 5'd4,  8'd0,  4'd0});
    vecs.push_back('{2, 5'd30, 8'd0,  4'd0});
    vecs.push_back('{3, 5'd0,  8'd0,  4'd1});
    vecs.push_back('{3, 5'd1,  8'd1,  4'd1});
    vecs.push_back('{3, 5'd3,  8'd0,  4'd0});
    vecs.push_back('{5, 5'd5,  8'd0,  4'd2});
    vecs.push_back('{5, 5'd6,  8'd1,  4'd2});
    vecs.push_back('{5, 5'd7,  8'd2,  4'd2});
    vecs.push_back('{5, 5'd8,  8'd3,  4'd2});
    vecs.push_back('{5, 5'd0,  8'd0,  4'd0});
    vecs.push_back('{5, 5'd2,  8'd0,  4'd0});
    vecs.push_back('{6, 5'd0,  8'd0,  4'd0});
    vecs.push_back('{6, 5'd28, 8'd0,  4'd0});

    tree1 = {29{4'd5}};
    tree2 = '0;
    tree2[3:0] = 4'd1; tree2[7:4] = 4'd2; tree2[11:8] = 4'd3; tree2[15:12] = 4'd3;
    tree3 = '0;
    tree3[3:0] = 4'd1; tree3[7:4] = 4'd1; tree3[11:8] = 4'd1;
    tree5 = '0;
    tree5[23:20] = 4'd2; tree5[27:24] = 4'd2; tree5[31:28] = 4'd2; tree5[35:32] = 4'd2;

    rst = 1'b1; enb = 1'b0; litTree = '0; litSymb = '0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    $display("[TB] all symbols length 5, pulsed enb");
    buildTree("s1", tree1, 0);
    runVectors(1);
    checkVal("s1_err", err_oversub, 0);

    $display("[TB] mixed lengths, enb held during scan");
    buildTree("s2", tree2, 10);
    runVectors(2);
    checkVal("s2_err", err_oversub, 0);

    $display("[TB] oversubscribed length-1 codes");
    buildTree("s3", tree3, 0);
    runVectors(3);
    checkVal("s3_err", err_oversub, 1);

    $display("[TB] reset in the middle of a build");
    @(negedge clk);
    litTree = tree1;
    enb     = 1'b1;
    @(posedge clk);
    #1;
    enb = 1'b0;
    repeat (50) @(posedge clk);
    applyStimulus(5'd0, 8'd0, 4'd0);
    checkOutput("during_build");
    repeat (45) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkAllZero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    buildTree("s4", tree2, 0);
    runVectors(2);

    $display("[TB] rebuild with a different tree");
    buildTree("s5", tree5, 0);
    runVectors(5);
    checkVal("s5_err", err_oversub, 0);

    $display("[TB] all-zero tree");
    buildTree("s6", '0, 0);
    runVectors(6);
    checkVal("s6_err", err_oversub, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
